// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous RAM (1-cycle read latency)
// between a never-stalled video fetch port and a CPU port handled by a small
// IDLE/ISSUED/ACK FSM. Video always has priority; the CPU gets a fixed
// issue-to-ack latency of two cycles.
// Optional feature macro: VRAM_ARBITER_STATS_EN enables the saturating CPU
// stall counter on cpu_stall_cnt; without it the port is tied to zero.
module vram_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_ack,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_dout,
    output logic              vid_valid,
    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [15:0]       cpu_stall_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUED = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                op_we_q, op_we_d;
    logic [DATA_W-1:0]   cpu_dout_q, cpu_dout_d;
    logic                vid_valid_q, vid_valid_d;
    logic                cpu_issue;

    // CPU access goes out only from IDLE and only when video leaves the port free
    assign cpu_issue = (state_q == ST_IDLE) && cpu_req && !vid_req;

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (cpu_issue) state_d = ST_ISSUED;
            ST_ISSUED: state_d = ST_ACK;
            ST_ACK:    state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM / port outputs: video owns the RAM whenever it asks, else the CPU in IDLE
    always_comb begin
        ram_ce   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (resetn) begin
            if (vid_req) begin
                ram_ce   = 1'b1;
                ram_addr = vid_addr;
            end else if (cpu_issue) begin
                ram_ce   = 1'b1;
                ram_we   = cpu_we;
                ram_addr = cpu_addr;
                ram_din  = cpu_din;
            end
        end
        cpu_ack = (state_q == ST_ACK);
    end

    // Datapath next values: latch operation type, capture read data leaving ISSUED
    always_comb begin
        op_we_d     = op_we_q;
        cpu_dout_d  = cpu_dout_q;
        vid_valid_d = vid_req;
        if (cpu_issue) begin
            op_we_d = cpu_we;
        end
        if ((state_q == ST_ISSUED) && !op_we_q) begin
            cpu_dout_d = ram_dout;
        end
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            op_we_q     <= 1'b0;
            cpu_dout_q  <= '0;
            vid_valid_q <= 1'b0;
        end else begin
            op_we_q     <= op_we_d;
            cpu_dout_q  <= cpu_dout_d;
            vid_valid_q <= vid_valid_d;
        end
    end

    assign cpu_dout  = cpu_dout_q;
    assign vid_valid = vid_valid_q;
    // RAM read data for a video fetch arrives exactly in the vid_valid cycle
    assign vid_dout  = ram_dout;

`ifdef VRAM_ARBITER_STATS_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Stall counter next value: count IDLE cycles where video blocks a CPU request, saturating
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((state_q == ST_IDLE) && cpu_req && vid_req && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk) begin
        if (!resetn) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign cpu_stall_cnt = stall_cnt_q;
`else
    assign cpu_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed testbench for vram_arbiter with a behavioural 1-cycle-latency RAM.
module tb_vram_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 8;

    logic              clk;
    logic              resetn;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_din;
    logic [DATA_W-1:0] cpu_dout;
    logic              cpu_ack;
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic [DATA_W-1:0] vid_dout;
    logic              vid_valid;
    logic              ram_ce;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic [15:0]       cpu_stall_cnt;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_checks = 0;
    int n_fail   = 0;

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_dout(vid_dout), .vid_valid(vid_valid),
        .ram_ce(ram_ce), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_dout(ram_dout), .cpu_stall_cnt(cpu_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port synchronous RAM, read data one cycle after the enable
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) mem[ram_addr] <= ram_din;
            else        ram_dout      <= mem[ram_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One CPU access with no video traffic: issue n, ack n+2, release n+3
    task automatic cpu_rw(input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] din, input logic [DATA_W-1:0] exp_dout);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_din = din; vid_req = 1'b0;
        @(negedge clk);
        check_eq("issue_ce", ram_ce, 1);
        check_eq("issue_we", ram_we, we);
        check_eq("issue_addr", ram_addr, addr);
        if (we) check_eq("issue_din", ram_din, din);
        check_eq("ack_n", cpu_ack, 0);
        next_cycle();
        @(negedge clk);
        check_eq("ack_n1", cpu_ack, 0);
        check_eq("issued_ce", ram_ce, 0);
        next_cycle();
        @(negedge clk);
        check_eq("ack_n2", cpu_ack, 1);
        check_eq("dout_n2", cpu_dout, exp_dout);
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        check_eq("ack_n3", cpu_ack, 0);
        check_eq("dout_n3", cpu_dout, exp_dout);
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'h00;
        mem[12'h4C0] = 8'h5A;
        mem[12'h020] = 8'h33;
        mem[12'h030] = 8'hC3;
        mem[12'h040] = 8'h77;
        mem[12'h200] = 8'h11;
        mem[12'h201] = 8'h22;
        for (int i = 0; i < 5; i++) mem[12'h100 + i] = 8'h80 + 8'(i);
        ram_dout = '0;

        // Reset with both requesters active: RAM must stay disabled
        resetn = 1'b0; cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 12'h123; cpu_din = 8'hEE;
        vid_req = 1'b1; vid_addr = 12'h321;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_eq("rst_ce", ram_ce, 0);
        check_eq("rst_we", ram_we, 0);
        check_eq("rst_ack", cpu_ack, 0);
        check_eq("rst_vvalid", vid_valid, 0);
        check_eq("rst_dout", cpu_dout, 0);
        check_eq("rst_stall", cpu_stall_cnt, 0);
        cpu_req = 1'b0; vid_req = 1'b0;
        next_cycle();
        resetn = 1'b1;
        next_cycle();
        @(negedge clk);
        check_eq("idle_ce", ram_ce, 0);
        check_eq("idle_we", ram_we, 0);
        next_cycle();

        // Basic read
        cpu_rw(1'b0, 12'h4C0, 8'h00, 8'h5A);
        // Write then read back; the write leaves cpu_dout untouched
        cpu_rw(1'b1, 12'h010, 8'hA5, 8'h5A);
        check_eq("mem_written", mem[12'h010], 8'hA5);
        cpu_rw(1'b0, 12'h010, 8'h00, 8'hA5);

        // Video holds off a CPU read for 5 cycles
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h020;
        for (int i = 0; i < 5; i++) begin
            vid_req = 1'b1; vid_addr = 12'h100 + 12'(i);
            @(negedge clk);
            check_eq("stall_ce", ram_ce, 1);
            check_eq("stall_we", ram_we, 0);
            check_eq("stall_addr", ram_addr, 12'h100 + 12'(i));
            check_eq("stall_ack", cpu_ack, 0);
            if (i > 0) begin
                check_eq("stall_vvalid", vid_valid, 1);
                check_eq("stall_vdout", vid_dout, 8'h80 + 8'(i - 1));
            end
            next_cycle();
        end
        vid_req = 1'b0;
        @(negedge clk);
        check_eq("v5_valid", vid_valid, 1);
        check_eq("v5_dout", vid_dout, 8'h84);
        check_eq("late_issue_addr", ram_addr, 12'h020);
        check_eq("late_issue_ce", ram_ce, 1);
`ifdef VRAM_ARBITER_STATS_EN
        check_eq("stall_cnt5", cpu_stall_cnt, 5);
`else
        check_eq("stall_cnt0", cpu_stall_cnt, 0);
`endif
        next_cycle();
        @(negedge clk);
        check_eq("late_vvalid0", vid_valid, 0);
        check_eq("late_ack_n1", cpu_ack, 0);
        next_cycle();
        @(negedge clk);
        check_eq("late_ack_n2", cpu_ack, 1);
        check_eq("late_dout", cpu_dout, 8'h33);
        next_cycle();
        cpu_req = 1'b0;
        next_cycle();

        // Video in ISSUED and ACK cycles of a CPU read
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h030;
        next_cycle();
        vid_req = 1'b1; vid_addr = 12'h200;
        @(negedge clk);
        check_eq("iss_vid_addr", ram_addr, 12'h200);
        check_eq("iss_vid_ce", ram_ce, 1);
        check_eq("iss_vid_we", ram_we, 0);
        next_cycle();
        vid_addr = 12'h201;
        @(negedge clk);
        check_eq("ack_vvalid", vid_valid, 1);
        check_eq("ack_vdout", vid_dout, 8'h11);
        check_eq("ack_cpu", cpu_ack, 1);
        check_eq("ack_cpu_dout", cpu_dout, 8'hC3);
        next_cycle();
        cpu_req = 1'b0; vid_req = 1'b0;
        @(negedge clk);
        check_eq("post_vvalid", vid_valid, 1);
        check_eq("post_vdout", vid_dout, 8'h22);
        check_eq("post_cpu_dout", cpu_dout, 8'hC3);
        check_eq("post_ack", cpu_ack, 0);
        next_cycle();

        // Reset during ISSUED drops the access; held request re-issues
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h040;
        next_cycle();
        resetn = 1'b0; vid_req = 1'b1; vid_addr = 12'h200;
        @(negedge clk);
        check_eq("rstiss_ce", ram_ce, 0);
        check_eq("rstiss_ack", cpu_ack, 0);
        next_cycle();
        resetn = 1'b1; vid_req = 1'b0;
        @(negedge clk);
        check_eq("rst2_ack", cpu_ack, 0);
        check_eq("rst2_vvalid", vid_valid, 0);
        check_eq("rst2_dout", cpu_dout, 0);
        check_eq("rst2_stall", cpu_stall_cnt, 0);
        check_eq("reissue_ce", ram_ce, 1);
        check_eq("reissue_addr", ram_addr, 12'h040);
        next_cycle();
        @(negedge clk);
        check_eq("reissue_ack_n1", cpu_ack, 0);
        next_cycle();
        @(negedge clk);
        check_eq("reissue_ack_n2", cpu_ack, 1);
        check_eq("reissue_dout", cpu_dout, 8'h77);
        next_cycle();
        cpu_req = 1'b0;
        next_cycle();

        // Long stall: counter saturates
        cpu_req = 1'b1; cpu_addr = 12'h020; vid_req = 1'b1; vid_addr = 12'h000;
`ifdef VRAM_ARBITER_STATS_EN
        for (int i = 0; i < 65534; i++) next_cycle();
        @(negedge clk);
        check_eq("sat_fffe", cpu_stall_cnt, 16'hFFFE);
        for (int i = 0; i < 4466; i++) next_cycle();
        @(negedge clk);
        check_eq("sat_ffff", cpu_stall_cnt, 16'hFFFF);
`else
        for (int i = 0; i < 20; i++) next_cycle();
        @(negedge clk);
        check_eq("nostats_zero", cpu_stall_cnt, 0);
`endif
        check_eq("sat_no_ack", cpu_ack, 0);
        next_cycle();
        cpu_req = 1'b0; vid_req = 1'b0;
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
